// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Encodings 011/110/111 fall through to word accesses.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = SZ_B;
            2'b01:   access_size = SZ_H;
            default: access_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load extraction/extension,
// and misalignment detection (active only with LSU_MISALIGN_TRAP_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_funct3,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_funct3,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  lane [4];
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_signed;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = ld_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
        case (access_size(st_funct3))
            SZ_B: begin
                st_wstrb = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_wstrb = 4'b0011 << {st_offset[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte   = lane[ld_offset];
    assign ld_half   = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    assign ld_signed = ~ld_funct3[2];

    always_comb begin
        ld_data = ld_word;
        case (access_size(ld_funct3))
            SZ_B:    ld_data = {{24{ld_byte[7] & ld_signed}}, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15] & ld_signed}}, ld_half};
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (access_size(st_funct3))
            SZ_H:    misaligned = st_offset[0];
            SZ_W:    misaligned = |st_offset;
            default: ;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: one outstanding valid/ready bus access with pipeline stall.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into a bus-free trap.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] write_data_m,
    input  logic [2:0]  funct3_m,
    output logic [31:0] read_data_m,
    output logic        stall_m,
    output logic        bus_err_m,
    output logic        misaligned_m,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic        bus_req_we,
    output logic [3:0]  bus_req_wstrb,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              req_valid_reg;
    logic [31:0]       req_addr_reg;
    logic              req_we_reg;
    logic [3:0]        req_wstrb_reg;
    logic [31:0]       req_wdata_reg;
    logic [31:0]       read_data_reg;
    logic              bus_err_reg;
    logic              misaligned_reg;
    logic [1:0]        ld_offset_reg;
    logic [2:0]        ld_funct3_reg;

    logic        access;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic        misaligned;
    logic [31:0] ld_data;

    assign access = mem_read_m | mem_write_m;

    lsu_align u_align (
        .st_offset  (addr_m[1:0]),
        .st_funct3  (funct3_m),
        .st_data    (write_data_m),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_offset  (ld_offset_reg),
        .ld_funct3  (ld_funct3_reg),
        .ld_word    (bus_resp_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            req_valid_reg  <= 1'b0;
            req_addr_reg   <= '0;
            req_we_reg     <= 1'b0;
            req_wstrb_reg  <= '0;
            req_wdata_reg  <= '0;
            read_data_reg  <= '0;
            bus_err_reg    <= 1'b0;
            misaligned_reg <= 1'b0;
            ld_offset_reg  <= '0;
            ld_funct3_reg  <= '0;
        end else begin
            bus_err_reg    <= 1'b0;
            misaligned_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        ld_offset_reg <= addr_m[1:0];
                        ld_funct3_reg <= funct3_m;
                        if (misaligned) begin
                            state_reg      <= DONE;
                            read_data_reg  <= '0;
                            misaligned_reg <= 1'b1;
                        end else begin
                            // A simultaneous read+write resolves to a store.
                            state_reg     <= REQ;
                            cnt_reg       <= '0;
                            req_valid_reg <= 1'b1;
                            req_addr_reg  <= {addr_m[31:2], 2'b00};
                            req_we_reg    <= mem_write_m;
                            req_wstrb_reg <= mem_write_m ? st_wstrb : 4'b0000;
                            req_wdata_reg <= mem_write_m ? st_wdata : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        state_reg     <= WAIT;
                        req_valid_reg <= 1'b0;
                        cnt_reg       <= cnt_reg + CNT_W'(1);
                    end else if (cnt_reg >= TIMEOUT_LAST) begin
                        state_reg     <= DONE;
                        req_valid_reg <= 1'b0;
                        read_data_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (bus_resp_valid) begin
                        state_reg     <= DONE;
                        read_data_reg <= req_we_reg ? 32'd0 : ld_data;
                    end else if (cnt_reg >= TIMEOUT_LAST) begin
                        state_reg     <= DONE;
                        read_data_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        stall_m = 1'b0;
        case (state_reg)
            IDLE:    stall_m = access;
            REQ:     stall_m = 1'b1;
            WAIT:    stall_m = 1'b1;
            default: stall_m = 1'b0;
        endcase
    end

    assign bus_req_valid = req_valid_reg;
    assign bus_req_addr  = req_addr_reg;
    assign bus_req_we    = req_we_reg;
    assign bus_req_wstrb = req_wstrb_reg;
    assign bus_req_wdata = req_wdata_reg;
    assign read_data_m   = read_data_reg;
    assign bus_err_m     = bus_err_reg;
    assign misaligned_m  = misaligned_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES overridden to 8).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_m, mem_write_m;
    logic [31:0] addr_m, write_data_m;
    logic [2:0]  funct3_m;
    logic [31:0] read_data_m;
    logic        stall_m, bus_err_m, misaligned_m;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_req_addr;
    logic        bus_req_we;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last run_access call.
    int          r_stalls, r_valid_cycles;
    logic        r_done, r_stable, r_err, r_mis;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_m     (mem_read_m),
        .mem_write_m    (mem_write_m),
        .addr_m         (addr_m),
        .write_data_m   (write_data_m),
        .funct3_m       (funct3_m),
        .read_data_m    (read_data_m),
        .stall_m        (stall_m),
        .bus_err_m      (bus_err_m),
        .misaligned_m   (misaligned_m),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_we     (bus_req_we),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_req_wdata  (bus_req_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_rdata (bus_resp_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Presents one access at a negedge and acts as the bus: ready after ready_wait
    // request cycles, response one cycle after the handshake (unless respond=0).
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [2:0] f3, input logic [31:0] wd,
                              input logic [31:0] rdata, input int ready_wait,
                              input logic respond);
        int   req_cyc = 0;
        logic hs = 1'b0;
        mem_read_m = rd; mem_write_m = wr; addr_m = a; funct3_m = f3; write_data_m = wd;
        r_stalls = 0; r_valid_cycles = 0; r_done = 1'b0; r_stable = 1'b1;
        r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
        for (int c = 0; c < 64 && !r_done; c++) begin
            #1;
            if (!stall_m) begin
                r_done = 1'b1;
                r_rdata = read_data_m; r_err = bus_err_m; r_mis = misaligned_m;
            end else begin
                r_stalls++;
                bus_resp_valid = hs & respond;
                bus_resp_rdata = rdata;
                hs = 1'b0;
                if (bus_req_valid) begin
                    if (r_valid_cycles == 0) begin
                        r_addr = bus_req_addr; r_wdata = bus_req_wdata;
                        r_wstrb = bus_req_wstrb; r_we = bus_req_we;
                    end else if (bus_req_addr !== r_addr || bus_req_wdata !== r_wdata ||
                                 bus_req_wstrb !== r_wstrb || bus_req_we !== r_we) begin
                        r_stable = 1'b0;
                    end
                    r_valid_cycles++;
                    bus_req_ready = (req_cyc >= ready_wait);
                    hs = bus_req_ready;
                    req_cyc++;
                end else begin
                    bus_req_ready = 1'b0;
                end
                @(negedge clk);
            end
        end
        check("access_completes", {31'd0, r_done}, 32'd1);
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        $display("txn a=%h f3=%b rd=%0d wr=%0d stalls=%0d data=%h err=%0d mis=%0d",
                 a, f3, rd, wr, r_stalls, r_rdata, r_err, r_mis);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        mem_read_m = 0; mem_write_m = 0; addr_m = 0; write_data_m = 0; funct3_m = 0;
        bus_req_ready = 0; bus_resp_valid = 0; bus_resp_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_stall", {31'd0, stall_m}, 32'd0);
        check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst_rdata", read_data_m, 32'd0);
        check("rst_err", {31'd0, bus_err_m}, 32'd0);
        check("rst_wstrb", {28'd0, bus_req_wstrb}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // LW, zero-wait bus
        run_access(1, 0, 32'h100, 3'b010, 32'd0, 32'hDEADBEEF, 0, 1);
        check("lw_stalls", r_stalls, 3);
        check("lw_data", r_rdata, 32'hDEADBEEF);
        check("lw_addr", r_addr, 32'h100);
        check("lw_we", {31'd0, r_we}, 32'd0);

        // Load lane selection and extension
        run_access(1, 0, 32'h103, 3'b000, 32'd0, 32'h80FFFF7F, 0, 1);
        check("lb_sext", r_rdata, 32'hFFFFFF80);
        run_access(1, 0, 32'h103, 3'b100, 32'd0, 32'h80FFFF7F, 0, 1);
        check("lbu_zext", r_rdata, 32'h00000080);
        run_access(1, 0, 32'h102, 3'b101, 32'd0, 32'h80FFFF7F, 0, 1);
        check("lhu_zext", r_rdata, 32'h000080FF);
        run_access(1, 0, 32'h102, 3'b001, 32'd0, 32'h80FFFF7F, 0, 1);
        check("lh_sext", r_rdata, 32'hFFFF80FF);
        run_access(1, 0, 32'h100, 3'b000, 32'd0, 32'h80FFFF7F, 0, 1);
        check("lb_pos", r_rdata, 32'h0000007F);

        // Stores
        run_access(0, 1, 32'h106, 3'b001, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1);
        check("sh_wstrb", {28'd0, r_wstrb}, 32'hC);
        check("sh_wdata", r_wdata, 32'hABCDABCD);
        check("sh_addr", r_addr, 32'h104);
        check("sh_we", {31'd0, r_we}, 32'd1);
        check("sh_stalls", r_stalls, 3);
        run_access(0, 1, 32'h101, 3'b000, 32'h0000005A, 32'd0, 0, 1);
        check("sb_wstrb", {28'd0, r_wstrb}, 32'h2);
        check("sb_wdata", r_wdata, 32'h5A5A5A5A);
        run_access(1, 1, 32'h200, 3'b010, 32'hCAFEF00D, 32'd0, 0, 1);
        check("rdwr_we", {31'd0, r_we}, 32'd1);
        check("sw_wstrb", {28'd0, r_wstrb}, 32'hF);
        check("sw_wdata", r_wdata, 32'hCAFEF00D);

        // Backpressure: ready low for 5 request cycles
        run_access(1, 0, 32'h40, 3'b010, 32'd0, 32'h13572468, 5, 1);
        check("bp_valid_cycles", r_valid_cycles, 6);
        check("bp_stable", {31'd0, r_stable}, 32'd1);
        check("bp_stalls", r_stalls, 8);
        check("bp_data", r_rdata, 32'h13572468);

        // Timeout: no response ever arrives
        run_access(1, 0, 32'h300, 3'b010, 32'd0, 32'h55555555, 0, 0);
        check("to_stalls", r_stalls, 9);
        check("to_err", {31'd0, r_err}, 32'd1);
        check("to_rdata", r_rdata, 32'd0);
        check("to_err_pulse", {31'd0, bus_err_m}, 32'd0);
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h99999999;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        #1;
        check("late_resp_rdata", read_data_m, 32'd0);
        check("late_resp_stall", {31'd0, stall_m}, 32'd0);

        // Reset while in WAIT
        mem_read_m = 1; addr_m = 32'h500; funct3_m = 3'b010;
        @(negedge clk);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        check("wait_stall", {31'd0, stall_m}, 32'd1);
        rst = 1'b1; mem_read_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_wait_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst_wait_stall", {31'd0, stall_m}, 32'd0);
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h77777777;
        @(negedge clk);
        bus_resp_valid = 1'b0;
        check("rst_late_rdata", read_data_m, 32'd0);
        check("rst_late_stall", {31'd0, stall_m}, 32'd0);

        // Misaligned word
`ifdef LSU_MISALIGN_TRAP_EN
        run_access(1, 0, 32'h102, 3'b010, 32'd0, 32'h11223344, 0, 1);
        check("mis_stalls", r_stalls, 1);
        check("mis_flag", {31'd0, r_mis}, 32'd1);
        check("mis_no_req", r_valid_cycles, 0);
        check("mis_rdata", r_rdata, 32'd0);
`else
        run_access(1, 0, 32'h102, 3'b010, 32'd0, 32'h11223344, 0, 1);
        check("mis_stalls", r_stalls, 3);
        check("mis_flag", {31'd0, r_mis}, 32'd0);
        check("mis_addr", r_addr, 32'h100);
        check("mis_rdata", r_rdata, 32'h11223344);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
